key_sys_ctrl: RTL
=================

# key_sys_ctrl

Push-button front end that produces the `system_en` level consumed by the LED flasher stage. It synchronizes and debounces an active-low mechanical key, emits a one-cycle press pulse, and toggles `system_en` on each accepted press. An optional auto-off timer drops `system_en` after a fixed on-time.

## Interface
- `DEB_MAX`, 32'd999_999, debounce window terminal count (20 ms at 50 MHz)
- `TIMEOUT_MAX`, 32'd499_999_999, auto-off terminal count (10 s at 50 MHz); used only when auto-off is compiled in
- `clk`  input  1  system clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `key_in`  input  1  raw key, active-low (0 = pressed), asynchronous to `clk`
- `key_flag`  output  1  one-cycle pulse per accepted press
- `system_en`  output  1  enable level to the LED flasher; 1 = flashing
- `timeout_flag`  output  1  one-cycle pulse when the auto-off timer fires

## Operation
- Reset values: `key_flag`=0, `system_en`=0, `timeout_flag`=0; sync flops=1; FSM=IDLE; all counters=0.
- Synchronizer: 2-FF chain on `key_in`, reset to 1. Output is `key_s`.
- Debounce FSM, 32-bit counter `cnt`:
  - IDLE: if `key_s`=0, go to PRESS_FILT with `cnt`=0.
  - PRESS_FILT: if `key_s`=1, return to IDLE. Else if `cnt`==`DEB_MAX`, go to HELD and assert `key_flag`. Else `cnt`+1.
  - HELD: if `key_s`=1, go to RELEASE_FILT with `cnt`=0.
  - RELEASE_FILT: if `key_s`=0, return to HELD with no new pulse. Else if `cnt`==`DEB_MAX`, go to IDLE. Else `cnt`+1.
- A bounce shorter than `DEB_MAX`+1 cycles never produces a pulse.
- Holding the key produces exactly one pulse. The release must also be stable before another press is accepted.
- `system_en` toggles on the same edge that `key_flag` asserts.
- Auto-off timer, 32-bit `tcnt`:
  - Cleared while `system_en`=0.
  - Increments while `system_en`=1.
  - When `tcnt`==`TIMEOUT_MAX`: `system_en` is forced to 0, `timeout_flag` pulses, and `tcnt` is cleared.
  - An accepted press while on turns the block off and clears `tcnt`. An accepted press while off starts a fresh on-time from 0.
- Simultaneous accepted press and timeout in one cycle: `system_en`=0 and `timeout_flag`=1. Only one transition to 0 occurs, and no re-enable.
- Counters never wrap; they are bounded by their terminal compares.

## Timing
- Latency: if `key_in` is first sampled low at edge 1 and stays low, `key_s`=0 after edge 2 and PRESS_FILT is entered at edge 3. `key_flag` and the `system_en` toggle register at edge `DEB_MAX`+4.
- `key_flag` and `timeout_flag` are exactly 1 cycle wide.
- `system_en` falls at edge `TIMEOUT_MAX`+1 after the edge on which it rose, counting a continuous on-time.
- Reset mid-operation: all state returns to reset values asynchronously. A key held through the reset release is treated as a new press and needs the full debounce window.

## Configuration
- Macro: `KEY_SYS_AUTO_OFF_EN`.
- Defined: auto-off timer present, behaving as described under Operation.
- Undefined: no `tcnt` logic, and `timeout_flag` is tied to 0. `system_en` changes only on accepted presses. `TIMEOUT_MAX` is accepted but unused.

## Structure
- Shared package `led_sys_pkg` holds:
  - Debounce state encoding: IDLE=2'd0, PRESS_FILT=2'd1, HELD=2'd2, RELEASE_FILT=2'd3.
  - Default constants for 50 MHz: `DEB_MAX`, `TIMEOUT_MAX`, and the flasher's 0.5 s count.
- Sub-module `key_debounce` contains the synchronizer, FSM and `cnt`, and outputs `key_flag`.
- The top level `key_sys_ctrl` contains the `system_en` toggle register and the optional auto-off timer.

## Test plan
All scenarios use `DEB_MAX`=4 and `TIMEOUT_MAX`=20.
- Clean press: hold `key_in`=0 for 30 cycles, then release for 30 cycles → one `key_flag` pulse at edge 8 after first low sample; `system_en` 0→1 on the same edge.
- Bounce: toggle `key_in` low/high every 3 cycles for 24 cycles, then stable high → no `key_flag`; `system_en` stays 0.
- Release bounce: clean press, then 2-cycle high glitches while held → exactly one pulse.
  - A second clean press after a stable release → second pulse; `system_en` 1→0.
- Auto-off (macro defined): single press, no further input → `system_en`=1 for exactly 21 cycles, then 0, with a one-cycle `timeout_flag`.
  - With the macro undefined: `system_en` stays 1 for 200+ cycles and `timeout_flag` is never 1.
- Collision (macro defined): align the press accept edge with the `tcnt`==20 edge → `system_en`=0, `timeout_flag`=1 and `key_flag`=1 on the same cycle; no re-enable.
- Reset mid-press: assert `rst_n`=0 during PRESS_FILT while the key is held → outputs are 0 immediately.
  - After `rst_n` releases with the key still held → one pulse arrives 8 edges later.

Source files
------------

// File: rtl/led_sys_pkg.sv
// Shared definitions for the key / LED flasher system.
// Holds the debounce state encoding and the default 50 MHz terminal counts.
package led_sys_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_FILT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_FILT = 2'd3
    } deb_state_e;

    // 20 ms debounce window at 50 MHz
    localparam logic [31:0] DEB_MAX_DFLT     = 32'd999_999;
    // 10 s auto-off on-time at 50 MHz
    localparam logic [31:0] TIMEOUT_MAX_DFLT = 32'd499_999_999;
    // 0.5 s LED flasher half-period at 50 MHz
    localparam logic [31:0] FLASH_MAX_DFLT   = 32'd24_999_999;

endpackage

// File: rtl/key_sys_ctrl_if.sv
// Signal bundle between the key front end and its environment.
// The slave side is the key_sys_ctrl block; the master side drives the raw key.
interface key_sys_ctrl_if;

    logic key_in;
    logic key_flag;
    logic system_en;
    logic timeout_flag;

    modport master (
        output key_in,
        input  key_flag,
        input  system_en,
        input  timeout_flag
    );

    modport slave (
        input  key_in,
        output key_flag,
        output system_en,
        output timeout_flag
    );

endinterface

// File: rtl/key_sys_ctrl_key_debounce.sv
// key_debounce: 2-FF synchronizer plus press/release debounce FSM.
// key_flag_o is a registered one-cycle pulse per accepted press; accept_o is
// its next-state value so the parent can act on the same clock edge.
module key_debounce
    import led_sys_pkg::*;
#(
    parameter logic [31:0] DEB_MAX = DEB_MAX_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic key_flag_o,
    output logic accept_o
);

    logic        sync1_q;
    logic        key_s_q;
    deb_state_e  state_q;
    logic [31:0] cnt_q;
    logic        key_flag_q;
    logic        key_flag_d;

    // Bring the asynchronous key into the clock domain; idle level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            key_s_q <= 1'b1;
        end else begin
            sync1_q <= key_i;
            key_s_q <= sync1_q;
        end
    end

    assign key_flag_d = (state_q == PRESS_FILT) && !key_s_q && (cnt_q == DEB_MAX);

    // Debounce FSM: a level must stay stable for DEB_MAX+1 cycles to count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_flag_q <= 1'b0;
        end else begin
            key_flag_q <= key_flag_d;
            case (state_q)
                IDLE: begin
                    if (!key_s_q) begin
                        state_q <= PRESS_FILT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_FILT: begin
                    if (key_s_q) begin
                        state_q <= IDLE;
                    end else if (cnt_q == DEB_MAX) begin
                        state_q <= HELD;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                HELD: begin
                    if (key_s_q) begin
                        state_q <= RELEASE_FILT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_FILT: begin
                    if (!key_s_q) begin
                        state_q <= HELD;
                    end else if (cnt_q == DEB_MAX) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_flag_o = key_flag_q;
    assign accept_o   = key_flag_d;

endmodule

// File: rtl/key_sys_ctrl.sv
// key_sys_ctrl: debounced push-button that toggles system_en for the flasher.
// Optional auto-off timer compiled in with macro KEY_SYS_AUTO_OFF_EN.
module key_sys_ctrl
    import led_sys_pkg::*;
#(
    parameter logic [31:0] DEB_MAX     = DEB_MAX_DFLT,
    parameter logic [31:0] TIMEOUT_MAX = TIMEOUT_MAX_DFLT
) (
    input  logic           clk,
    input  logic           rst_n,
    key_sys_ctrl_if.slave  key_bus
);

    logic key_flag;
    logic accept;
    logic system_en_q;
    logic timeout_flag_q;

    key_debounce #(
        .DEB_MAX (DEB_MAX)
    ) u_key_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_i      (key_bus.key_in),
        .key_flag_o (key_flag),
        .accept_o   (accept)
    );

`ifdef KEY_SYS_AUTO_OFF_EN
    logic [31:0] tcnt_q;
    logic        timeout_d;

    assign timeout_d = system_en_q && (tcnt_q == TIMEOUT_MAX);

    // Toggle on each press; the timer wins a same-cycle collision so the block ends off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            system_en_q    <= 1'b0;
            timeout_flag_q <= 1'b0;
            tcnt_q         <= '0;
        end else begin
            timeout_flag_q <= timeout_d;
            if (timeout_d) begin
                system_en_q <= 1'b0;
            end else if (accept) begin
                system_en_q <= ~system_en_q;
            end
            if (!system_en_q || timeout_d || accept) begin
                tcnt_q <= '0;
            end else begin
                tcnt_q <= tcnt_q + 32'd1;
            end
        end
    end
`else
    logic unused_timeout_max;

    assign unused_timeout_max = ^TIMEOUT_MAX;
    assign timeout_flag_q     = 1'b0;

    // Toggle the enable level on every accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            system_en_q <= 1'b0;
        end else if (accept) begin
            system_en_q <= ~system_en_q;
        end
    end
`endif

    assign key_bus.key_flag     = key_flag;
    assign key_bus.system_en    = system_en_q;
    assign key_bus.timeout_flag = timeout_flag_q;

endmodule
